// File: rtl/wb_pkg.sv
// Shared Wishbone RAM responder definitions: bus widths and responder FSM states.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_ram_core.sv
// Single-port WORDS x 32 RAM with byte-lane write enables and a registered read port
// that returns zero in any cycle without a read access.
module wb_ram_core
  import wb_pkg::*;
#(
  parameter int WORDS = 512,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [SEL_W-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // NOTE: the storage array is deliberately left out of reset; only control and
  // output registers are cleared, so RAM contents survive wb_rst.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int lane = 0; lane < SEL_W; lane++) begin
        if (be[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  // Read data is held only for the single cycle after a read access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/wb_ram_resp.sv
// Wishbone classic RAM responder with WAIT extra cycles before a single-cycle ack.
// Optional macro WB_RAM_ADDR_CHECK_EN adds an err output for out-of-range addresses.
module wb_ram_resp
  import wb_pkg::*;
#(
  parameter int WORDS = 512,
  parameter int WAIT  = 0
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              cyc,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] dat,
  output logic              ack,
  output logic [DATA_W-1:0] rdt
`ifdef WB_RAM_ADDR_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT > 0) ? CW'(WAIT - 1) : '0;

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          go_ack;
  logic          addr_bad;
  logic          ram_en;
  logic          unused_adr_bits;

`ifdef WB_RAM_ADDR_CHECK_EN
  assign addr_bad        = |adr[ADDR_W-1:AW+2];
  assign unused_adr_bits = ^adr[1:0];
`else
  assign addr_bad        = 1'b0;
  assign unused_adr_bits = ^{adr[ADDR_W-1:AW+2], adr[1:0]};
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    go_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cyc) begin
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          state_d = ST_ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ack   <= go_ack;
    end
  end

`ifdef WB_RAM_ADDR_CHECK_EN
  always_ff @(posedge wb_clk) begin
    if (wb_rst) err <= 1'b0;
    else        err <= go_ack && addr_bad;
  end
`endif

  // Reset wins over an access on the same edge; a rejected address never reaches the RAM.
  assign ram_en = go_ack && !addr_bad && !wb_rst;

  wb_ram_core #(
    .WORDS(WORDS)
  ) u_core (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .en   (ram_en),
    .we   (we),
    .be   (sel),
    .addr (adr[AW+1:2]),
    .wdata(dat),
    .rdata(rdt)
  );

endmodule

// File: tb/tb_wb_ram_resp.sv
// Directed bench for wb_ram_resp: instance 0 with WAIT=0, instance 1 with WAIT=3.
// Build with WB_RAM_ADDR_CHECK_EN defined to exercise the err output.
module tb_wb_ram_resp;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [1:0]        cyc_v, we_v, ack_v;
  logic [1:0][3:0]   sel_v;
  logic [1:0][31:0]  adr_v, dat_v, rdt_v;
`ifdef WB_RAM_ADDR_CHECK_EN
  logic [1:0]        err_v;
`endif

  int passed = 0;
  int total  = 0;

  always #5 wb_clk = ~wb_clk;

  wb_ram_resp #(.WORDS(512), .WAIT(0)) dut0 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cyc(cyc_v[0]), .we(we_v[0]), .sel(sel_v[0]),
    .adr(adr_v[0]), .dat(dat_v[0]), .ack(ack_v[0]), .rdt(rdt_v[0])
`ifdef WB_RAM_ADDR_CHECK_EN
    , .err(err_v[0])
`endif
  );

  wb_ram_resp #(.WORDS(512), .WAIT(3)) dut3 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cyc(cyc_v[1]), .we(we_v[1]), .sel(sel_v[1]),
    .adr(adr_v[1]), .dat(dat_v[1]), .ack(ack_v[1]), .rdt(rdt_v[1])
`ifdef WB_RAM_ADDR_CHECK_EN
    , .err(err_v[1])
`endif
  );

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // Runs one transfer; lat is the cycle (1 = cycle after cyc rose) in which ack was seen.
  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] x, output int lat, output logic [31:0] rd,
                      output logic er, output logic leak);
    cyc_v[d] = 1'b1; we_v[d] = w; sel_v[d] = s; adr_v[d] = a; dat_v[d] = x;
    lat = -1; rd = '0; er = 1'b0; leak = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack_v[d] === 1'b1) begin
        lat = i;
        rd  = rdt_v[d];
`ifdef WB_RAM_ADDR_CHECK_EN
        er  = err_v[d];
`endif
        break;
      end
      if (rdt_v[d] !== 32'h0) leak = 1'b1;
    end
    cyc_v[d] = 1'b0; we_v[d] = 1'b0; sel_v[d] = 4'h0;
    tick();
    if (ack_v[d] !== 1'b0 || rdt_v[d] !== 32'h0) leak = 1'b1;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    cyc_v = '0; we_v = '0; sel_v = '0; adr_v = '0; dat_v = '0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ack_v[d] !== 1'b0 || rdt_v[d] !== 32'h0)
        $display("FAIL reset_out[%0d]: ack=%b rdt=%h required ack=0 rdt=0", d, ack_v[d], rdt_v[d]);
      else passed++;
    end
    wb_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd; logic er, leak;
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h12343456, lat, rd, er, leak);
    total++;
    if (lat !== 1) $display("FAIL basic_wr_lat: got %0d required 1", lat); else passed++;
    total++;
    if (rd !== 32'h0 || leak !== 1'b0)
      $display("FAIL basic_wr_rdt: rdt=%h leak=%b required 0", rd, leak);
    else passed++;
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, er, leak);
    total++;
    if (lat !== 1) $display("FAIL basic_rd_lat: got %0d required 1", lat); else passed++;
    total++;
    if (rd !== 32'h12343456) $display("FAIL basic_rd_data: got %h required 12343456", rd);
    else passed++;
    total++;
    if (leak !== 1'b0) $display("FAIL basic_rd_leak: rdt or ack nonzero outside ack cycle");
    else passed++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic er, leak;
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hCAFECAFE, lat, rd, er, leak);
    xfer(0, 1'b1, 4'h1, 32'h10, 32'h000000AA, lat, rd, er, leak);
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er, leak);
    total++;
    if (rd !== 32'hCAFECAAA) $display("FAIL lane_sel1: got %h required cafecaaa", rd); else passed++;
    xfer(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, lat, rd, er, leak);
    total++;
    if (lat !== 1) $display("FAIL lane_sel0_ack: got lat %0d required 1", lat); else passed++;
    xfer(0, 1'b1, 4'hA, 32'h10, 32'h11223344, lat, rd, er, leak);
    xfer(0, 1'b0, 4'hF, 32'h13, 32'h0, lat, rd, er, leak);
    total++;
    if (rd !== 32'h11FE33AA) $display("FAIL lane_sel_a_lowbits: got %h required 11fe33aa", rd);
    else passed++;
`ifndef WB_RAM_ADDR_CHECK_EN
    xfer(0, 1'b0, 4'hF, 32'h00000810, 32'h0, lat, rd, er, leak);
    total++;
    if (rd !== 32'h11FE33AA) $display("FAIL alias_rd: got %h required 11fe33aa", rd); else passed++;
`endif
  endtask

  task automatic test_wait3();
    int lat, acks; logic [31:0] rd; logic er, leak;
    xfer(1, 1'b1, 4'hF, 32'h40, 32'h55AA55AA, lat, rd, er, leak);
    total++;
    if (lat !== 4) $display("FAIL w3_wr_lat: got %0d required 4", lat); else passed++;
    xfer(1, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, er, leak);
    total++;
    if (lat !== 4 || rd !== 32'h55AA55AA || leak !== 1'b0)
      $display("FAIL w3_rd: lat=%0d rdt=%h leak=%b required 4/55aa55aa/0", lat, rd, leak);
    else passed++;
    cyc_v[1] = 1'b1; we_v[1] = 1'b1; sel_v[1] = 4'hF; adr_v[1] = 32'h40; dat_v[1] = 32'hDEADBEEF;
    tick();
    cyc_v[1] = 1'b0; we_v[1] = 1'b0;
    acks = 0;
    repeat (8) begin
      tick();
      if (ack_v[1] !== 1'b0) acks++;
    end
    total++;
    if (acks !== 0) $display("FAIL w3_abort_ack: got %0d ack cycles required 0", acks); else passed++;
    xfer(1, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, er, leak);
    total++;
    if (rd !== 32'h55AA55AA) $display("FAIL w3_abort_data: got %h required 55aa55aa", rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, first, second, high, wn; logic [31:0] rd, d0, d1; logic er, leak;
    for (int d = 0; d < 2; d++) begin
      wn = (d == 0) ? 0 : 3;
      xfer(d, 1'b1, 4'hF, 32'h0, 32'h0, lat, rd, er, leak);
      xfer(d, 1'b1, 4'hF, 32'h4, 32'h11111111, lat, rd, er, leak);
      cyc_v[d] = 1'b1; we_v[d] = 1'b0; sel_v[d] = 4'hF; adr_v[d] = 32'h0;
      first = -1; second = -1; high = 0; d0 = 'x; d1 = 'x;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (ack_v[d] === 1'b1) begin
          high++;
          if (first < 0) begin
            first = i; d0 = rdt_v[d]; adr_v[d] = 32'h4;
          end else if (second < 0) begin
            second = i; d1 = rdt_v[d]; cyc_v[d] = 1'b0;
          end
        end
        if (second >= 0 && i >= second + 3) break;
      end
      cyc_v[d] = 1'b0;
      total++;
      if (first !== wn + 1 || second - first !== wn + 2)
        $display("FAIL b2b_spacing[%0d]: first=%0d second=%0d required %0d/%0d",
                 d, first, second, wn + 1, 2 * wn + 3);
      else passed++;
      total++;
      if (d0 !== 32'h0 || d1 !== 32'h11111111)
        $display("FAIL b2b_data[%0d]: got %h,%h required 00000000,11111111", d, d0, d1);
      else passed++;
      total++;
      if (high !== 2) $display("FAIL b2b_ack_width[%0d]: got %0d ack cycles required 2", d, high);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int lat, acks, wn; logic [31:0] rd; logic er, leak;
    for (int d = 0; d < 2; d++) begin
      wn = (d == 0) ? 0 : 3;
      xfer(d, 1'b1, 4'hF, 32'h8, 32'h88888888, lat, rd, er, leak);
      cyc_v[d] = 1'b1; we_v[d] = 1'b1; sel_v[d] = 4'hF; adr_v[d] = 32'h8; dat_v[d] = 32'hFFFFFFFF;
      repeat (wn) tick();
      wb_rst = 1'b1;
      tick();
      total++;
      if (ack_v[d] !== 1'b0 || rdt_v[d] !== 32'h0)
        $display("FAIL rst_abort_out[%0d]: ack=%b rdt=%h required 0/0", d, ack_v[d], rdt_v[d]);
      else passed++;
      wb_rst = 1'b0; cyc_v[d] = 1'b0; we_v[d] = 1'b0;
      acks = 0;
      repeat (6) begin
        tick();
        if (ack_v[d] !== 1'b0) acks++;
      end
      xfer(d, 1'b0, 4'hF, 32'h8, 32'h0, lat, rd, er, leak);
      total++;
      if (acks !== 0 || rd !== 32'h88888888)
        $display("FAIL rst_abort_mem[%0d]: acks=%0d rdt=%h required 0/88888888", d, acks, rd);
      else passed++;
    end
  endtask

  task automatic test_addr_check();
    int lat; logic [31:0] rd; logic er, leak;
    xfer(0, 1'b1, 4'hF, 32'h0, 32'h01020304, lat, rd, er, leak);
    total++;
    if (er !== 1'b0 || lat !== 1) $display("FAIL addr_ok: err=%b lat=%0d required 0/1", er, lat);
    else passed++;
    xfer(0, 1'b1, 4'hF, 32'h00001000, 32'hA5A5A5A5, lat, rd, er, leak);
    total++;
    if (lat !== 1) $display("FAIL addr_hi_lat: got %0d required 1", lat); else passed++;
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, er, leak);
`ifdef WB_RAM_ADDR_CHECK_EN
    total++;
    if (rd !== 32'h01020304) $display("FAIL addr_err_nowrite: got %h required 01020304", rd);
    else passed++;
    xfer(0, 1'b0, 4'hF, 32'h00001000, 32'h0, lat, rd, er, leak);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1)
      $display("FAIL addr_err_rd: err=%b rdt=%h lat=%0d required 1/0/1", er, rd, lat);
    else passed++;
`else
    total++;
    if (rd !== 32'hA5A5A5A5) $display("FAIL addr_alias_wr: got %h required a5a5a5a5", rd);
    else passed++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait3();
    test_back_to_back();
    test_reset_abort();
    test_addr_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_ram_resp.md
WB_RAM_RESP -- requirements
Module: wb_ram_resp

Interface
- REQ-001 Parameter WORDS, default 512: RAM depth in 32-bit words; power of two; AW = $clog2(WORDS).
- REQ-002 Parameter WAIT, default 0: extra wait cycles inserted before ack.
- REQ-003 wb_clk  in  1  sole clock; all state updates on its rising edge.
- REQ-004 wb_rst  in  1  reset, synchronous, active-high.
- REQ-005 cyc  in  1  initiator requests a transfer; held until ack sampled.
- REQ-006 we  in  1  1 = write, 0 = read.
- REQ-007 sel  in  4  byte-lane write enables; bit n gates dat[8n+7:8n].
- REQ-008 adr  in  32  byte address; word index = adr[AW+1:2].
- REQ-009 dat  in  32  write data.
- REQ-010 ack  out  1  registered one-cycle transfer-complete strobe.
- REQ-011 rdt  out  32  registered read data; valid only while ack=1.

Function
- REQ-012 The block SHALL implement a three-state FSM: IDLE, WAIT, ACK.
- REQ-013 IDLE, cyc=1 at edge: go to WAIT with counter loaded to WAIT-1 if WAIT>0, else go to ACK.
- REQ-014 WAIT: the counter SHALL decrement each edge; at 0 with cyc=1 go to ACK.
- REQ-015 WAIT, cyc=0 at any edge: abort, return to IDLE; no RAM write, no ack.
- REQ-016 The RAM access SHALL occur on the edge entering ACK, using adr/we/sel/dat sampled at that edge.
- REQ-017 Write: only lanes with sel[n]=1 updated; sel=0 writes nothing but still acks.
- REQ-018 Read: rdt loaded with the addressed word on entry to ACK; read-before-write not applicable (one access per transfer).
- REQ-019 ack SHALL be 1 for exactly one cycle (state ACK), then FSM unconditionally returns to IDLE.
- REQ-020 rdt SHALL be 0 in every cycle ack=0 and during write acks.
- REQ-021 Latency: ack high in cycle WAIT+1 after first cycle cyc=1 (WAIT=0: the next cycle).
- REQ-022 Back-to-back: cyc held high after ack starts a new transfer from IDLE; minimum spacing between acks is WAIT+2 cycles.
- REQ-023 Address bits above AW+1 and adr[1:0] SHALL be ignored (aliasing modulo WORDS) unless WB_RAM_ADDR_CHECK_EN.

Reset
- REQ-024 wb_rst=1 at an edge: FSM to IDLE, counter 0, ack 0, rdt 0, err 0; takes priority over any access on that edge.
- REQ-025 Reset SHALL NOT clear RAM contents; an in-flight write not yet committed is discarded.

Configuration
- REQ-026 Macro WB_RAM_ADDR_CHECK_EN defined: add output err (1 bit, registered); access with any of adr[31:AW+2] nonzero SHALL complete with err=1, ack=1 for the same single cycle, no RAM write, rdt 0.
- REQ-027 Macro undefined: no err port; addresses alias per REQ-023.

Structure
- REQ-028 Shared package wb_pkg SHALL hold the FSM state enum, the 32-bit data/address width constants and the 4-bit sel width.
- REQ-029 Storage SHALL be a sub-module wb_ram_core: single-port, byte-enabled, registered read, WORDS x 32; FSM/counter stay in wb_ram_resp.

Verification
- REQ-030 WAIT=0: write 0x20 <- 0x12343456 sel=1111, then read 0x20 -> ack one cycle after cyc, rdt=0x12343456 only during ack, 0 otherwise.
- REQ-031 Byte lanes: write 0x10 <- 0xCAFECAFE, then write 0x10 <- 0x000000AA sel=0001, read -> 0xCAFECAAA.
- REQ-032 WAIT=3: read request -> ack in 4th cycle after cyc; cyc dropped in 2nd cycle of a write -> no ack, subsequent read returns old value.
- REQ-033 cyc held high across two reads (0x0, 0x4 holding 0x0, 0x11111111) -> two single-cycle acks spaced WAIT+2, correct data each.
- REQ-034 wb_rst asserted in the edge entering ACK of a write to 0x8 -> ack never seen, 0x8 unchanged, ack/rdt 0 after reset.
- REQ-035 WB_RAM_ADDR_CHECK_EN: write to 0x00001000 (WORDS=512) -> ack with err=1, word 0x0 unchanged; without macro the same write lands at word 0.
